// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states, counter-op encodings and decode bundle
// for the multi-cycle control sequencer.
package ctrl_pkg;

  localparam int unsigned OP_ADD    = 1;
  localparam int unsigned OP_SUB    = 2;
  localparam int unsigned OP_MUL    = 3;
  localparam int unsigned OP_AND    = 4;
  localparam int unsigned OP_OR     = 5;
  localparam int unsigned OP_NOT    = 6;
  localparam int unsigned OP_XOR    = 7;
  localparam int unsigned OP_LSHIFT = 8;
  localparam int unsigned OP_RSHIFT = 9;
  localparam int unsigned OP_GT     = 10;
  localparam int unsigned OP_LT     = 11;
  localparam int unsigned OP_EQ     = 12;
  localparam int unsigned OP_CSET   = 13;
  localparam int unsigned OP_CINC   = 14;
  localparam int unsigned OP_CDEC   = 15;
  localparam int unsigned OP_ADDC   = 16;
  localparam int unsigned OP_MAX    = 16;

  localparam logic [1:0] CNT_NONE = 2'b00;
  localparam logic [1:0] CNT_SET  = 2'b01;
  localparam logic [1:0] CNT_INC  = 2'b10;
  localparam logic [1:0] CNT_DEC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  typedef struct packed {
    logic       regwrite;
    logic       flag_we;
    logic       cnt_en;
    logic [1:0] cnt_op;
    logic       carry_sel;
    logic       is_mul;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode classifier: class strobes, counter op,
// carry select, multi-cycle flag and illegal detection.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output dec_t             dec
);

  logic [31:0] op;

  always_comb begin
    op  = 32'(opc);
    dec = '0;
    unique case (1'b1)
      (op == 0) || (op > OP_MAX): begin
        dec.illegal = 1'b1;
      end
      (op == OP_MUL): begin
        dec.regwrite = 1'b1;
        dec.is_mul   = 1'b1;
      end
      (op >= OP_ADD) && (op <= OP_RSHIFT) && (op != OP_MUL): begin
        dec.regwrite = 1'b1;
      end
      (op == OP_ADDC): begin
        dec.regwrite  = 1'b1;
        dec.carry_sel = 1'b1;
      end
      (op >= OP_GT) && (op <= OP_EQ): begin
        dec.flag_we = 1'b1;
      end
      (op == OP_CSET): begin
        dec.cnt_en = 1'b1;
        dec.cnt_op = CNT_SET;
      end
      (op == OP_CINC): begin
        dec.cnt_en = 1'b1;
        dec.cnt_op = CNT_INC;
      end
      (op == OP_CDEC): begin
        dec.cnt_en = 1'b1;
        dec.cnt_op = CNT_DEC;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: IDLE -> DECODE -> EXEC -> WB with
// registered strobes, MUL latency, execute stall and retire counter.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int OPC_W      = 5,
  parameter int REG_AW     = 3,
  parameter int ALU_CTRL_W = 8,
  parameter int MUL_LAT    = 3,
  parameter int RET_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  exec_stall,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [REG_AW-1:0]     rd_addr,
  output logic [REG_AW-1:0]     ra_addr,
  output logic [REG_AW-1:0]     rb_addr,
  output logic                  regwrite,
  output logic                  flag_we,
  output logic                  cnt_en,
  output logic [1:0]            cnt_op,
  output logic                  carry_sel,
  output logic                  illegal_op,
  output logic                  done,
  output logic [RET_W-1:0]      retired
);

  localparam int CW = $clog2(MUL_LAT + 1);

  state_t           state;
  dec_t             dec_in;
  dec_t             dec_q;
  logic [OPC_W-1:0] opc_q;
  logic [CW-1:0]    cnt;
  logic             unused_instr;

  assign unused_instr = ^instr;

  ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opc (instr[OPC_W-1:0]),
    .dec (dec_in)
  );

  // Decode is registered at capture so illegal_op lands in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      alu_ctrl    <= '0;
      rd_addr     <= '0;
      ra_addr     <= '0;
      rb_addr     <= '0;
      regwrite    <= 1'b0;
      flag_we     <= 1'b0;
      cnt_en      <= 1'b0;
      cnt_op      <= CNT_NONE;
      carry_sel   <= 1'b0;
      illegal_op  <= 1'b0;
      done        <= 1'b0;
      retired     <= '0;
      dec_q       <= '0;
      opc_q       <= '0;
      cnt         <= '0;
    end else begin
      regwrite   <= 1'b0;
      flag_we    <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_op     <= CNT_NONE;
      illegal_op <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            rd_addr     <= instr[INSTR_W-1 -: REG_AW];
            ra_addr     <= instr[INSTR_W-1-REG_AW -: REG_AW];
            rb_addr     <= instr[INSTR_W-1-2*REG_AW -: REG_AW];
            opc_q       <= instr[OPC_W-1:0];
            dec_q       <= dec_in;
            illegal_op  <= dec_in.illegal;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (dec_q.illegal) begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt       <= dec_q.is_mul ? CW'(MUL_LAT) : CW'(1);
            alu_ctrl  <= ALU_CTRL_W'(opc_q);
            carry_sel <= dec_q.carry_sel;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!exec_stall) begin
            if (cnt == CW'(1)) begin
              regwrite <= dec_q.regwrite;
              flag_we  <= dec_q.flag_we;
              cnt_en   <= dec_q.cnt_en;
              cnt_op   <= dec_q.cnt_op;
              done     <= 1'b1;
              retired  <= retired + RET_W'(1);
              state    <= WB;
            end
            cnt <= cnt - CW'(1);
          end
        end
        WB: begin
          alu_ctrl    <= '0;
          carry_sel   <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed and random instructions against a
// per-cycle expectation model built from the opcode/timing rules.
module tb_control_sequencer;

  localparam int INSTR_W    = 16;
  localparam int OPC_W      = 5;
  localparam int REG_AW     = 3;
  localparam int ALU_CTRL_W = 8;
  localparam int MUL_LAT    = 3;
  localparam int RET_W      = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  instr_valid = 1'b0;
  logic                  instr_ready;
  logic [INSTR_W-1:0]    instr = '0;
  logic                  exec_stall = 1'b0;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [REG_AW-1:0]     rd_addr;
  logic [REG_AW-1:0]     ra_addr;
  logic [REG_AW-1:0]     rb_addr;
  logic                  regwrite;
  logic                  flag_we;
  logic                  cnt_en;
  logic [1:0]            cnt_op;
  logic                  carry_sel;
  logic                  illegal_op;
  logic                  done;
  logic [RET_W-1:0]      retired;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  control_sequencer #(
    .INSTR_W    (INSTR_W),
    .OPC_W      (OPC_W),
    .REG_AW     (REG_AW),
    .ALU_CTRL_W (ALU_CTRL_W),
    .MUL_LAT    (MUL_LAT),
    .RET_W      (RET_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .exec_stall  (exec_stall),
    .alu_ctrl    (alu_ctrl),
    .rd_addr     (rd_addr),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .regwrite    (regwrite),
    .flag_we     (flag_we),
    .cnt_en      (cnt_en),
    .cnt_op      (cnt_op),
    .carry_sel   (carry_sel),
    .illegal_op  (illegal_op),
    .done        (done),
    .retired     (retired)
  );

  typedef struct {
    bit         legal;
    bit         rw;
    bit         fw;
    bit         ce;
    logic [1:0] cop;
    bit         cs;
    int         lat;
  } exp_t;

  function automatic exp_t model(input int op);
    exp_t e;
    e.legal = (op >= 1) && (op <= 16);
    e.lat   = (op == 3) ? MUL_LAT : 1;
    e.rw    = ((op >= 1) && (op <= 9)) || (op == 16);
    e.fw    = (op >= 10) && (op <= 12);
    e.ce    = (op >= 13) && (op <= 15);
    e.cop   = e.ce ? 2'(op - 12) : 2'd0;
    e.cs    = (op == 16);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [15:0] w, input int st_at,
                     input int st_len, input bit hold);
    exp_t e;
    int   op;
    int   wb;
    int   last;
    op   = int'(w[4:0]);
    e    = model(op);
    wb   = 2 + e.lat + st_len;
    last = e.legal ? wb : 1;
    @(negedge clk);
    chk("idle_ready", 32'(instr_ready), 32'd1);
    chk("idle_alu", 32'(alu_ctrl), 32'd0);
    chk("idle_retired", 32'(retired), 32'(exp_ret));
    instr       = w;
    instr_valid = 1'b1;
    exec_stall  = 1'($urandom);
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      instr_valid = hold;
      instr       = 16'($urandom);
      if (c == 1 || c == wb)
        exec_stall = 1'($urandom);
      else
        exec_stall = (c >= 2 + st_at) && (c < 2 + st_at + st_len);
      chk("busy_ready", 32'(instr_ready), 32'd0);
      chk("illegal_op", 32'(illegal_op), 32'(!e.legal && c == 1));
      chk("alu_ctrl", 32'(alu_ctrl),
          (e.legal && c >= 2 && c <= wb) ? 32'(op) : 32'd0);
      chk("carry_sel", 32'(carry_sel),
          32'(e.cs && c >= 2 && c <= wb));
      chk("regwrite", 32'(regwrite), 32'(e.rw && c == wb));
      chk("flag_we", 32'(flag_we), 32'(e.fw && c == wb));
      chk("cnt_en", 32'(cnt_en), 32'(e.ce && c == wb));
      chk("cnt_op", 32'(cnt_op), (c == wb) ? 32'(e.cop) : 32'd0);
      chk("done", 32'(done), 32'(e.legal && c == wb));
      if (e.legal && c == wb) exp_ret = (exp_ret + 1) % (1 << RET_W);
      chk("retired", 32'(retired), 32'(exp_ret));
      chk("rd_addr", 32'(rd_addr), 32'(w[15:13]));
      chk("ra_addr", 32'(ra_addr), 32'(w[12:10]));
      chk("rb_addr", 32'(rb_addr), 32'(w[9:7]));
    end
  endtask

  function automatic logic [15:0] rand_word(input logic [4:0] op);
    return {3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), op};
  endfunction

  task automatic run_rand(input bit legal_only);
    logic [4:0] op;
    int         len;
    int         at;
    if (legal_only) op = 5'($urandom_range(1, 16));
    else            op = 5'($urandom_range(0, 31));
    len = $urandom_range(0, 3);
    at  = (op == 5'd3) ? $urandom_range(0, MUL_LAT - 1) : 0;
    run(rand_word(op), at, len, 1'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_alu", 32'(alu_ctrl), 32'd0);
    chk("rst_strobes",
        32'({regwrite, flag_we, cnt_en, cnt_op, carry_sel, illegal_op, done}),
        32'd0);
    rst_n = 1'b1;

    run(16'h2481, 0, 0, 1'b0);
    run(rand_word(5'd3), 1, 2, 1'b0);
    run(rand_word(5'd13), 0, 0, 1'b1);
    run(rand_word(5'd14), 0, 0, 1'b0);
    run(rand_word(5'd15), 0, 0, 1'b1);
    run(rand_word(5'd16), 0, 1, 1'b0);
    run(rand_word(5'd0), 0, 0, 1'b1);
    run(rand_word(5'd17), 0, 0, 1'b0);
    run(rand_word(5'd12), 0, 0, 1'b0);
    run(rand_word(5'd3), 0, 0, 1'b1);
    for (int i = 0; i < 24; i++) run_rand(1'b0);

    @(negedge clk);
    instr       = {3'd2, 3'd3, 3'd4, 2'b00, 5'd3};
    instr_valid = 1'b1;
    exec_stall  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mul_exec_alu", 32'(alu_ctrl), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", 32'(instr_ready), 32'd1);
    chk("async_retired", 32'(retired), 32'd0);
    chk("async_alu", 32'(alu_ctrl), 32'd0);
    chk("async_rd", 32'(rd_addr), 32'd0);
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_regwrite", 32'(regwrite), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
    end

    for (int i = 0; i < 17; i++) run_rand(1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("wrap_retired", 32'(retired), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
